// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared types and constants for the SHA-3 pad sequencer (SHA3_PAD_KECCAK_LEGACY_EN selects Keccak domain byte)
package sha3_pkg;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    FULL
  } sha3_state_e;

`ifdef SHA3_PAD_KECCAK_LEGACY_EN
  localparam logic [7:0] SHA3_DOMAIN_BYTE = 8'h01;
`else
  localparam logic [7:0] SHA3_DOMAIN_BYTE = 8'h06;
`endif

  localparam logic [7:0] SHA3_FINAL_BYTE = 8'h80;
  localparam int SHA3_RATE_WORDS = 18;

endpackage

// File: rtl/sha3_pad_sequencer_if.sv
// rtl/sha3_pad_sequencer_if.sv - message-in / block-out handshake bundle of the SHA-3 pad sequencer
interface sha3_pad_sequencer_if #(
  parameter int RATE_WORDS = 18
);

  logic [31:0]              in;
  logic                     in_valid;
  logic                     in_ready;
  logic                     is_last;
  logic [1:0]               byte_num;
  logic [32*RATE_WORDS-1:0] out;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     busy;

  // master: host bus and permutation core side; slave: the sequencer
  modport master (
    output in, in_valid, is_last, byte_num, out_ready,
    input  in_ready, out, out_valid, out_last, busy
  );

  modport slave (
    input  in, in_valid, is_last, byte_num, out_ready,
    output in_ready, out, out_valid, out_last, busy
  );

endinterface

// File: rtl/sha3_pad_word.sv
// rtl/sha3_pad_word.sv - combinational padding of the final message word (keep byte_num bytes, then domain byte, then zeros)
module sha3_pad_word (
  input  logic [31:0] word,
  input  logic [1:0]  byte_num,
  input  logic [7:0]  domain,
  output logic [31:0] padded
);

  always_comb begin
    padded = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(byte_num)) begin
        padded[31-8*i -: 8] = word[31-8*i -: 8];
      end else if (i == int'(byte_num)) begin
        padded[31-8*i -: 8] = domain;
      end
    end
  end

endmodule

// File: rtl/sha3_pad_sequencer.sv
// rtl/sha3_pad_sequencer.sv - assembles 32-bit message words into padded rate blocks for the Keccak core (SHA3_PAD_KECCAK_LEGACY_EN via sha3_pkg)
module sha3_pad_sequencer
  import sha3_pkg::*;
#(
  parameter int RATE_WORDS = SHA3_RATE_WORDS
) (
  input logic                 clk,
  input logic                 reset,
  sha3_pad_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(RATE_WORDS);

  sha3_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [32*RATE_WORDS-1:0] blk_q;
  logic                     pad_pending_q;
  logic                     out_last_q;
  logic                     busy_q;

  logic        accept;
  logic        load;
  logic        take;
  logic        last_slot;
  logic        final_d;
  logic [31:0] word_d;
  logic [31:0] padded;

  sha3_pad_word u_pad_word (
    .word     (bus.in),
    .byte_num (bus.byte_num),
    .domain   (SHA3_DOMAIN_BYTE),
    .padded   (padded)
  );

  assign last_slot = (cnt_q == CNT_W'(RATE_WORDS - 1));
  assign accept    = (state_q == FILL) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    take    = 1'b0;
    final_d = 1'b0;
    word_d  = '0;
    case (state_q)
      FILL: begin
        if (accept) begin
          load    = 1'b1;
          final_d = bus.is_last || pad_pending_q;
          word_d  = bus.is_last ? padded : bus.in;
          if (last_slot) begin
            state_d = FULL;
          end else if (bus.is_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        load    = 1'b1;
        final_d = pad_pending_q;
        if (last_slot) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          take    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    // last word of a padded block carries the closing 1 bit (merges with the domain byte when coincident)
    if (load && last_slot && final_d) begin
      word_d = word_d | {24'h0, SHA3_FINAL_BYTE};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      blk_q         <= '0;
      pad_pending_q <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if (load) begin
        blk_q <= {blk_q[32*(RATE_WORDS-1)-1:0], word_d};
        cnt_q <= last_slot ? '0 : cnt_q + 1'b1;
        if (last_slot) begin
          out_last_q <= final_d;
        end
      end
      if (accept) begin
        busy_q <= 1'b1;
        if (bus.is_last) begin
          pad_pending_q <= 1'b1;
        end
      end
      if (take) begin
        out_last_q <= 1'b0;
        if (out_last_q) begin
          busy_q        <= 1'b0;
          pad_pending_q <= 1'b0;
          blk_q         <= '0;
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == FILL) && !reset;
  assign bus.out       = blk_q;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/sha3_pad_sequencer.md
# sha3_pad_sequencer

Input-side controller for the SHA-3 core: accepts the message as a stream of 32-bit words, assembles them into rate-sized blocks, applies SHA-3 multi-rate padding (domain byte 0x06, final bit 0x80), and hands each complete block to the permutation core over a valid/ready handshake. It sits between the host bus interface and the Keccak-f round engine. It sequences the per-word padding cell and owns all block-fill, pad-fill and back-pressure state.

## Interface
- RATE_WORDS, 18, block size in 32-bit words (18 = 576-bit rate, SHA3-512).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in  in  32  message word, first byte in in[31:24].
- in_valid  in  1  `in`/`is_last`/`byte_num` are valid.
- in_ready  out  1  word accepted on an edge where in_valid && in_ready.
- is_last  in  1  word is the final message word.
- byte_num  in  2  when is_last: number of valid bytes (0..3) in `in`; ignored otherwise.
- out  out  32*RATE_WORDS  assembled block, word 0 in the MSBs.
- out_valid  out  1  block on `out` is complete.
- out_ready  in  1  core takes the block on an edge where out_valid && out_ready.
- out_last  out  1  qualifies out_valid: block is the final (padded) block.
- busy  out  1  high from the first accepted word until the final block is taken.

## Operation
- States: FILL, PAD, FULL.
- FILL: in_ready=1. Accepted non-last word is shifted into the buffer; word count cnt increments.
- Accepted last word: the buffer receives the padded word (n = byte_num valid bytes kept, byte n = 0x06, remaining bytes 0); pad_pending set; next state PAD, unless that word completes the block.
- Messages ending on a word boundary: the host sends an extra word with is_last=1, byte_num=0 (padded word 0x06000000).
- PAD: in_ready=0; one zero word shifted in per cycle until cnt = RATE_WORDS.
- When the word written has index RATE_WORDS-1 and pad_pending: OR 0x80 into its low byte, so 0x06 and 0x80 combine to 0x86 when coincident.
- On the edge writing word RATE_WORDS-1: cnt←0, next state FULL; out_last←pad_pending.
- FULL: out_valid=1, in_ready=0, `out` held stable.
- On handshake: next state FILL, out_valid←0.
- If out_last was set: busy←0, pad_pending←0, buffer cleared.
- out_valid is never withdrawn before the handshake.
- Reset mid-operation: state FILL, cnt 0, buffer 0, pad_pending 0. The partial message is discarded.

## Timing
- Reset values: out=0, out_valid=0, out_last=0, busy=0.
- in_ready is decoded from the state register and is forced 0 while reset is asserted.
- Non-final block: out_valid rises the cycle after the edge accepting word RATE_WORDS-1. Maximum input rate is one word per cycle.
- Final block: out_valid rises (RATE_WORDS-1-k)+1 cycles after the edge accepting the last word, where k is the last word's index in its block.
- FULL→FILL: one cycle. in_ready is high in the cycle after the out handshake; there is no bypass.
- cnt width is $clog2(RATE_WORDS); it never exceeds RATE_WORDS-1.

## Configuration
- SHA3_PAD_KECCAK_LEGACY_EN defined: domain byte 0x01 (original Keccak padding, e.g. Ethereum Keccak-256).
  - Padded last word for byte_num=0 is 0x01000000.
  - Coincident final byte is 0x81.
- Undefined (default): SHA-3 domain byte 0x06 as described above.
- No other behaviour differs between the two builds.

## Structure
- Shared package sha3_pkg:
  - state enum {FILL, PAD, FULL};
  - SHA3_DOMAIN_BYTE (0x06, or 0x01 under the macro);
  - SHA3_FINAL_BYTE (0x80);
  - default RATE_WORDS.
- Sub-module sha3_pad_word: purely combinational; (in, byte_num, domain byte) → padded 32-bit word. The sequencer owns all state.

## Test plan
- Empty message: word 0xDEADBEEF with is_last=1, byte_num=0 → single block with word0=0x06000000, words1–16=0, word17=0x00000080; out_last=1; out_valid rises 18 cycles after accept.
- 3-byte message: 0x61626300, is_last=1, byte_num=3 → word0=0x61626306, word17=0x00000080, out_last=1.
- Last word at index 17: 17 full words, then 0x11223344 with byte_num=3 → word17=0x11223386; out_valid the next cycle; no PAD cycles.
- Word-aligned boundary: 18 full words → block with out_last=0. Then a word with is_last=1, byte_num=0 → second block 0x06000000…0x00000080 with out_last=1.
- Back-pressure: hold out_ready=0 for 5 cycles in FULL → `out` stable, in_ready=0, out_valid=1 throughout. Handshake on the 6th cycle → in_ready=1 on the 7th.
- Reset asserted during PAD (cnt=9) → same cycle: out_valid=0, busy=0. After release: in_ready=1, and the next block begins at word0.
